mem_writeback_stage: RTL

Final pipeline stage, a parametrised successor to the plain writeback stage. It accepts one instruction per handshake and performs its data-memory access over a request/response handshake. Loads are aligned and sign/zero-extended. The block then commits exactly one register-file write per instruction and passes the PC onward. It also provides a forwarding port and reports misaligned-access exceptions.

---
 rtl/mem_wb_pkg.sv | 36 +++
 rtl/mem_writeback_stage_if.sv | 26 ++
 rtl/load_align_extend.sv | 37 +++
 rtl/mem_writeback_stage.sv | 141 ++++++++++++++
 4 files changed

// File: rtl/mem_wb_pkg.sv
// rtl/mem_wb_pkg.sv - shared state encoding, access-size constants and alignment helpers
package mem_wb_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_REQ   = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } wb_state_e;

  // funct3[1:0] selects the access size, funct3[2] selects zero-extension
  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;
  localparam logic [1:0] SZ_D = 2'b11;

  function automatic logic is_misaligned(input logic [1:0] size, input logic [2:0] addr_lo,
                                         input logic has_dword);
    case (size)
      SZ_B:    return 1'b0;
      SZ_H:    return addr_lo[0];
      SZ_W:    return addr_lo[1:0] != 2'b00;
      default: return !has_dword || (addr_lo != 3'b000);
    endcase
  endfunction

  function automatic logic [7:0] size_mask(input logic [1:0] size);
    case (size)
      SZ_B:    return 8'h01;
      SZ_H:    return 8'h03;
      SZ_W:    return 8'h0F;
      default: return 8'hFF;
    endcase
  endfunction

endpackage

// File: rtl/mem_writeback_stage_if.sv
// rtl/mem_writeback_stage_if.sv - data-memory request/response bus
interface mem_writeback_stage_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  localparam int STRB_WIDTH = DATA_WIDTH / 8;

  logic                  mem_req_valid;
  logic                  mem_req_ready;
  logic                  mem_req_write;
  logic [ADDR_WIDTH-1:0] mem_req_addr;
  logic [DATA_WIDTH-1:0] mem_req_wdata;
  logic [STRB_WIDTH-1:0] mem_req_strb;
  logic                  mem_resp_valid;
  logic [DATA_WIDTH-1:0] mem_resp_rdata;

  modport master (
    output mem_req_valid, mem_req_write, mem_req_addr, mem_req_wdata, mem_req_strb,
    input  mem_req_ready, mem_resp_valid, mem_resp_rdata
  );

  modport slave (
    input  mem_req_valid, mem_req_write, mem_req_addr, mem_req_wdata, mem_req_strb,
    output mem_req_ready, mem_resp_valid, mem_resp_rdata
  );
endinterface

// File: rtl/load_align_extend.sv
// rtl/load_align_extend.sv - selects the addressed lane of a load word and sign/zero-extends it
module load_align_extend
  import mem_wb_pkg::*;
#(
  parameter  int DATA_WIDTH = 32,
  localparam int LANE_W     = $clog2(DATA_WIDTH / 8)
) (
  input  logic [DATA_WIDTH-1:0] i_rdata,
  input  logic [LANE_W-1:0]     i_lane,
  input  logic [2:0]            i_funct3,
  output logic [DATA_WIDTH-1:0] o_data
);

  logic [DATA_WIDTH-1:0] w_shifted;

  assign w_shifted = i_rdata >> {i_lane, 3'b000};

  always_comb begin
    o_data = w_shifted;
    case (i_funct3[1:0])
      SZ_B: begin
        if (i_funct3[2]) o_data = DATA_WIDTH'(w_shifted[7:0]);
        else             o_data = DATA_WIDTH'($signed(w_shifted[7:0]));
      end
      SZ_H: begin
        if (i_funct3[2]) o_data = DATA_WIDTH'(w_shifted[15:0]);
        else             o_data = DATA_WIDTH'($signed(w_shifted[15:0]));
      end
      SZ_W: begin
        if (i_funct3[2]) o_data = DATA_WIDTH'(w_shifted[31:0]);
        else             o_data = DATA_WIDTH'($signed(w_shifted[31:0]));
      end
      default: o_data = w_shifted;
    endcase
  end

endmodule

// File: rtl/mem_writeback_stage.sv
// rtl/mem_writeback_stage.sv - final pipeline stage: data-memory access, load extension, register commit
module mem_writeback_stage
  import mem_wb_pkg::*;
#(
  parameter  int ADDR_WIDTH    = 32,
  parameter  int DATA_WIDTH    = 32,
  parameter  int NUM_REGISTERS = 32,
  localparam int STRB_WIDTH    = DATA_WIDTH / 8,
  localparam int REG_IDX_W     = $clog2(NUM_REGISTERS)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  prev_done,
  output logic                  stall_prev,
  input  logic                  next_stall,
  output logic                  done_next,
  input  logic [ADDR_WIDTH-1:0] program_count_in,
  input  logic                  load_in,
  input  logic                  store_in,
  input  logic                  write_enable_in,
  input  logic [2:0]            funct3_in,
  input  logic [REG_IDX_W-1:0]  write_register_in,
  input  logic [DATA_WIDTH-1:0] result_data_in,
  input  logic [DATA_WIDTH-1:0] store_data_in,
  mem_writeback_stage_if.master mem,
  output logic                  write_activate,
  output logic [REG_IDX_W-1:0]  write_register,
  output logic [DATA_WIDTH-1:0] write_data,
  output logic                  fwd_valid,
  output logic [REG_IDX_W-1:0]  fwd_register,
  output logic [DATA_WIDTH-1:0] fwd_data,
  output logic                  exception_valid,
  output logic [ADDR_WIDTH-1:0] program_count_out
);

  localparam int LANE_W = $clog2(STRB_WIDTH);

  wb_state_e             r_state, w_state_next, w_cap_state;
  logic [ADDR_WIDTH-1:0] r_pc;
  logic [REG_IDX_W-1:0]  r_rd;
  logic                  r_we, r_load, r_store, r_exc;
  logic [2:0]            r_funct3;
  logic [LANE_W-1:0]     r_lane;
  logic [DATA_WIDTH-1:0] r_result;
  logic [ADDR_WIDTH-1:0] r_req_addr;
  logic [DATA_WIDTH-1:0] r_req_wdata;
  logic [STRB_WIDTH-1:0] r_req_strb;

  logic                  w_capture, w_mem, w_mis;
  logic [LANE_W-1:0]     w_lane_in;
  logic [STRB_WIDTH-1:0] w_size_strb;
  logic [DATA_WIDTH-1:0] w_byte_mask, w_load_data;

  assign stall_prev = !rst_n || (r_state != ST_EMPTY && !(r_state == ST_DONE && !next_stall));
  assign w_capture  = prev_done && !stall_prev;
  assign w_mem      = load_in || store_in;
  assign w_mis      = w_mem && is_misaligned(funct3_in[1:0], result_data_in[2:0], DATA_WIDTH == 64);
  assign w_cap_state = (!w_mem || w_mis) ? ST_DONE : ST_REQ;
  assign w_lane_in  = result_data_in[LANE_W-1:0];
  assign w_size_strb = STRB_WIDTH'(size_mask(funct3_in[1:0]));

  always_comb begin
    w_byte_mask = '0;
    for (int i = 0; i < STRB_WIDTH; i++) w_byte_mask[8*i +: 8] = {8{w_size_strb[i]}};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_EMPTY;
    else        r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_EMPTY: if (w_capture) w_state_next = w_cap_state;
      ST_REQ:   if (mem.mem_req_ready) w_state_next = ST_WAIT;
      ST_WAIT:  if (mem.mem_resp_valid) w_state_next = ST_DONE;
      ST_DONE:  if (!next_stall) w_state_next = w_capture ? w_cap_state : ST_EMPTY;
      default:  w_state_next = ST_EMPTY;
    endcase
  end

  // Request fields are registered at capture so they stay stable across any ready delay
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc        <= '0;
      r_rd        <= '0;
      r_we        <= 1'b0;
      r_load      <= 1'b0;
      r_store     <= 1'b0;
      r_exc       <= 1'b0;
      r_funct3    <= '0;
      r_lane      <= '0;
      r_result    <= '0;
      r_req_addr  <= '0;
      r_req_wdata <= '0;
      r_req_strb  <= '0;
    end else if (w_capture) begin
      r_pc        <= program_count_in;
      r_rd        <= write_register_in;
      r_we        <= write_enable_in && !store_in;
      r_load      <= load_in;
      r_store     <= store_in;
      r_exc       <= w_mis;
      r_funct3    <= funct3_in;
      r_lane      <= w_lane_in;
      r_result    <= result_data_in;
      r_req_addr  <= {result_data_in[ADDR_WIDTH-1:LANE_W], {LANE_W{1'b0}}};
      r_req_wdata <= (store_data_in & w_byte_mask) << {w_lane_in, 3'b000};
      r_req_strb  <= w_size_strb << w_lane_in;
    end else if (r_state == ST_WAIT && mem.mem_resp_valid && r_load) begin
      r_result    <= w_load_data;
    end
  end

  load_align_extend #(.DATA_WIDTH(DATA_WIDTH)) u_align (
    .i_rdata  (mem.mem_resp_rdata),
    .i_lane   (r_lane),
    .i_funct3 (r_funct3),
    .o_data   (w_load_data)
  );

  assign mem.mem_req_valid = (r_state == ST_REQ);
  assign mem.mem_req_write = (r_state == ST_REQ) && r_store;
  assign mem.mem_req_addr  = r_req_addr;
  assign mem.mem_req_wdata = r_req_wdata;
  assign mem.mem_req_strb  = r_req_strb;

  assign done_next         = (r_state == ST_DONE);
  assign exception_valid   = (r_state == ST_DONE) && r_exc;
  assign write_activate    = (r_state == ST_DONE) && !next_stall && r_we && (r_rd != '0) && !r_exc;
  assign write_register    = r_rd;
  assign write_data        = r_result;
  assign fwd_valid         = r_we && (r_rd != '0) &&
                             ((r_state == ST_DONE) ||
                              ((r_state == ST_REQ || r_state == ST_WAIT) && !r_load));
  assign fwd_register      = r_rd;
  assign fwd_data          = r_result;
  assign program_count_out = r_pc;

endmodule
